// File: rtl/generador_interrupciones.sv
// -----------------------------------------------------------------------------
// generador_interrupciones
//
// Programmable interrupt source with three independent timer channels. Each
// channel has a period register and a sticky pending flag that drives one
// line of `interrupciones` until the CPU acknowledges it.
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   reset          synchronous, active-high reset (priority over everything)
//   we             register write strobe
//   dir            register address: 0..2 period of channel 0..2, 3 control/status
//   dato           write data (control: [2:0] enable, [5:3] one-shot mode)
//   reconocer      per-channel acknowledge, bit i clears pending i
//   dato_leido     combinational read data selected by dir
//                  (status: [8:6] overrun, [5:3] modo, [2:0] enable)
//   interrupciones registered pending flags, one per channel
// -----------------------------------------------------------------------------
module generador_interrupciones #(
    parameter int ANCHO = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [1:0]       dir,
    input  logic [ANCHO-1:0] dato,
    input  logic [2:0]       reconocer,
    output logic [ANCHO-1:0] dato_leido,
    output logic [2:0]       interrupciones
);

    logic [2:0]       enable_q, enable_d;
    logic [2:0]       modo_q, modo_d;
    logic [2:0]       pending_q, pending_d;
    logic [2:0]       overrun_q, overrun_d;
    logic [2:0]       fire;
    logic             wr_ctl;
    logic [ANCHO-1:0] periodo [3];

    // A control write touches every channel: it reloads enable/modo and
    // zeroes all counters, so it also suppresses any fire on that edge.
    assign wr_ctl = we && (dir == 2'd3);

    for (genvar gi = 0; gi < 3; gi++) begin : g_canal
        localparam logic [1:0] DIR_CANAL = 2'(gi);

        logic [ANCHO-1:0] periodo_q, periodo_d;
        logic [ANCHO-1:0] cnt_q, cnt_d;
        logic             wr_periodo;
        logic             activo;
        logic             llega;

        assign wr_periodo = we && (dir == DIR_CANAL);

        // Channel advances only when enabled, with a non-zero period and no
        // write aimed at it this edge; a write always wins over a fire.
        assign activo = enable_q[gi] && (periodo_q != '0) && !wr_periodo && !wr_ctl;

        // periodo_q - 1 wraps when the period is 0, but activo masks that case.
        assign llega    = (cnt_q == periodo_q - ANCHO'(1));
        assign fire[gi] = activo && llega;

        // Any non-counting situation parks the counter at 0, which also covers
        // the forced clear on period/control writes.
        assign cnt_d     = (activo && !llega) ? cnt_q + ANCHO'(1) : '0;
        assign periodo_d = wr_periodo ? dato : periodo_q;

        assign periodo[gi] = periodo_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                periodo_q <= '0;
                cnt_q     <= '0;
            end else begin
                periodo_q <= periodo_d;
                cnt_q     <= cnt_d;
            end
        end
    end

    always_comb begin
        enable_d  = enable_q;
        modo_d    = modo_q;
        overrun_d = overrun_q;
        if (wr_ctl) begin
            enable_d  = dato[2:0];
            modo_d    = dato[5:3];
            overrun_d = '0;
        end else begin
            // One-shot channels disarm themselves on the edge they fire.
            enable_d  = enable_q & ~(fire & modo_q);
            // A fire only overruns if the previous event is still unacknowledged
            // after this edge; an ack on the firing edge consumes the old event.
            overrun_d = overrun_q | (fire & pending_q & ~reconocer);
        end
        // Set beats clear so a fire coinciding with an ack is never lost.
        pending_d = fire | (pending_q & ~reconocer);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q  <= '0;
            modo_q    <= '0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            enable_q  <= enable_d;
            modo_q    <= modo_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        dato_leido = '0;
        case (dir)
            2'd0:    dato_leido = periodo[0];
            2'd1:    dato_leido = periodo[1];
            2'd2:    dato_leido = periodo[2];
            default: dato_leido[8:0] = {overrun_q, modo_q, enable_q};
        endcase
    end

    assign interrupciones = pending_q;

endmodule
